// File: rtl/img2col_addr_gen.sv
// im2col tensor-RAM read address generator for one convolution pass.
// Walks output pixels, then channel and kernel window, with zero-padding.
module img2col_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int KER_W  = 4,
    parameter int CH_W   = 8,
    parameter int STR_W  = 3,
    parameter int PAD_W  = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_tensor_size,
    input  logic [KER_W-1:0]  i_kernel_size,
    input  logic [CH_W-1:0]   i_channels,
    input  logic [STR_W-1:0]  i_stride,
    input  logic [PAD_W-1:0]  i_pad,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_pad,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_col_last,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int W2 = DIM_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              pad;
        logic              col_last;
        logic              last;
    } elem_t;

    // Output bundle for one element, given padded window origin and offsets.
    function automatic elem_t calc(
        input logic [W2-1:0]     py,
        input logic [W2-1:0]     px,
        input logic [CH_W-1:0]   ci,
        input logic [KER_W-1:0]  ky,
        input logic [KER_W-1:0]  kx,
        input logic [DIM_W-1:0]  h,
        input logic [KER_W-1:0]  k,
        input logic [CH_W-1:0]   c,
        input logic [STR_W-1:0]  s,
        input logic [PAD_W-1:0]  p,
        input logic [ADDR_W-1:0] base
    );
        logic [W2-1:0] hp;
        logic [W2-1:0] y;
        logic [W2-1:0] x;
        logic          y_out;
        logic          x_out;
        logic          end_y;
        logic          end_x;
        elem_t         e;
        hp    = W2'(h) + (W2'(p) << 1);
        y     = py + W2'(ky) - W2'(p);
        x     = px + W2'(kx) - W2'(p);
        y_out = y[W2-1] || (y >= W2'(h));
        x_out = x[W2-1] || (x >= W2'(h));
        e.pad = y_out || x_out;
        if (e.pad) begin
            e.addr = '0;
        end else begin
            e.addr = base
                   + ADDR_W'(ci) * ADDR_W'(h) * ADDR_W'(h)
                   + ADDR_W'(y[DIM_W-1:0]) * ADDR_W'(h)
                   + ADDR_W'(x[DIM_W-1:0]);
        end
        e.col_last = (ci == c - CH_W'(1))
                  && (ky == k - KER_W'(1))
                  && (kx == k - KER_W'(1));
        end_y  = (py + W2'(s) + W2'(k)) > hp;
        end_x  = (px + W2'(s) + W2'(k)) > hp;
        e.last = e.col_last && end_y && end_x;
        return e;
    endfunction

    state_t            state;
    logic [DIM_W-1:0]  cfg_h;
    logic [KER_W-1:0]  cfg_k;
    logic [CH_W-1:0]   cfg_c;
    logic [STR_W-1:0]  cfg_s;
    logic [PAD_W-1:0]  cfg_p;
    logic [ADDR_W-1:0] cfg_base;
    logic [W2-1:0]     cfg_hp;

    logic [W2-1:0]     py;
    logic [W2-1:0]     px;
    logic [CH_W-1:0]   ci;
    logic [KER_W-1:0]  ky;
    logic [KER_W-1:0]  kx;

    logic [W2-1:0]     n_py;
    logic [W2-1:0]     n_px;
    logic [CH_W-1:0]   n_ci;
    logic [KER_W-1:0]  n_ky;
    logic [KER_W-1:0]  n_kx;

    logic [W2-1:0]     in_hp;
    logic              legal;
    elem_t             first;
    elem_t             nxt;

    assign in_hp = W2'(i_tensor_size) + (W2'(i_pad) << 1);
    assign legal = (i_tensor_size != '0)
                && (i_kernel_size != '0)
                && (i_channels != '0)
                && (i_stride != '0)
                && (W2'(i_kernel_size) <= in_hp);

    // Odometer: kx fastest, then ky, channel, output x, output y.
    always_comb begin
        n_kx = kx + KER_W'(1);
        n_ky = ky;
        n_ci = ci;
        n_px = px;
        n_py = py;
        if (kx == cfg_k - KER_W'(1)) begin
            n_kx = '0;
            n_ky = ky + KER_W'(1);
            if (ky == cfg_k - KER_W'(1)) begin
                n_ky = '0;
                n_ci = ci + CH_W'(1);
                if (ci == cfg_c - CH_W'(1)) begin
                    n_ci = '0;
                    if (px + W2'(cfg_s) + W2'(cfg_k) <= cfg_hp) begin
                        n_px = px + W2'(cfg_s);
                    end else begin
                        n_px = '0;
                        n_py = py + W2'(cfg_s);
                    end
                end
            end
        end
    end

    assign first = calc('0, '0, '0, '0, '0,
                        i_tensor_size, i_kernel_size, i_channels,
                        i_stride, i_pad, i_base_addr);

    assign nxt = calc(n_py, n_px, n_ci, n_ky, n_kx,
                      cfg_h, cfg_k, cfg_c, cfg_s, cfg_p, cfg_base);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cfg_h      <= '0;
            cfg_k      <= '0;
            cfg_c      <= '0;
            cfg_s      <= '0;
            cfg_p      <= '0;
            cfg_base   <= '0;
            cfg_hp     <= '0;
            py         <= '0;
            px         <= '0;
            ci         <= '0;
            ky         <= '0;
            kx         <= '0;
            o_addr     <= '0;
            o_pad      <= 1'b0;
            o_valid    <= 1'b0;
            o_col_last <= 1'b0;
            o_last     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_err  <= 1'b0;
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        if (legal) begin
                            state      <= RUN;
                            cfg_h      <= i_tensor_size;
                            cfg_k      <= i_kernel_size;
                            cfg_c      <= i_channels;
                            cfg_s      <= i_stride;
                            cfg_p      <= i_pad;
                            cfg_base   <= i_base_addr;
                            cfg_hp     <= in_hp;
                            py         <= '0;
                            px         <= '0;
                            ci         <= '0;
                            ky         <= '0;
                            kx         <= '0;
                            o_addr     <= first.addr;
                            o_pad      <= first.pad;
                            o_col_last <= first.col_last;
                            o_last     <= first.last;
                            o_valid    <= 1'b1;
                            o_busy     <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (o_valid && i_ready) begin
                        if (o_last) begin
                            state      <= DONE;
                            o_valid    <= 1'b0;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                            o_addr     <= '0;
                            o_pad      <= 1'b0;
                            o_col_last <= 1'b0;
                            o_last     <= 1'b0;
                        end else begin
                            py         <= n_py;
                            px         <= n_px;
                            ci         <= n_ci;
                            ky         <= n_ky;
                            kx         <= n_kx;
                            o_addr     <= nxt.addr;
                            o_pad      <= nxt.pad;
                            o_col_last <= nxt.col_last;
                            o_last     <= nxt.last;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img2col_addr_gen.sv
// Randomised bench for img2col_addr_gen against a nested-loop im2col model.
// Checks element stream, markers, handshake, errors and reset abort.
module tb_img2col_addr_gen;

    logic        clk;
    logic        rstn;
    logic        i_start;
    logic [7:0]  i_tensor_size;
    logic [3:0]  i_kernel_size;
    logic [7:0]  i_channels;
    logic [2:0]  i_stride;
    logic [2:0]  i_pad;
    logic [15:0] i_base_addr;
    logic [15:0] o_addr;
    logic        o_pad;
    logic        o_valid;
    logic        i_ready;
    logic        o_col_last;
    logic        o_last;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int checks;
    int errors;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    img2col_addr_gen dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_start       (i_start),
        .i_tensor_size (i_tensor_size),
        .i_kernel_size (i_kernel_size),
        .i_channels    (i_channels),
        .i_stride      (i_stride),
        .i_pad         (i_pad),
        .i_base_addr   (i_base_addr),
        .o_addr        (o_addr),
        .o_pad         (o_pad),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_col_last    (o_col_last),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_out();
        return {13'd0, o_addr, o_pad, o_col_last, o_last};
    endfunction

    // Reference: textbook im2col loops with a divider for the output size.
    task automatic build_model(input int h, input int k, input int c,
                               input int s, input int p, input int base);
        int hp;
        int oh;
        int y;
        int x;
        int a;
        bit pd;
        bit cl;
        bit ls;
        exp_q.delete();
        hp = h + 2 * p;
        oh = (hp - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < oh; ox++)
                for (int cc = 0; cc < c; cc++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            y  = oy * s + ky - p;
                            x  = ox * s + kx - p;
                            pd = (y < 0) || (y >= h) || (x < 0) || (x >= h);
                            a  = pd ? 0 : ((base + cc*h*h + y*h + x) & 16'hffff);
                            cl = (cc == c-1) && (ky == k-1) && (kx == k-1);
                            ls = cl && (oy == oh-1) && (ox == oh-1);
                            exp_q.push_back({13'd0, a[15:0], pd, cl, ls});
                        end
    endtask

    task automatic drive_cfg(input int h, input int k, input int c,
                             input int s, input int p, input int base);
        i_tensor_size = 8'(h);
        i_kernel_size = 4'(k);
        i_channels    = 8'(c);
        i_stride      = 3'(s);
        i_pad         = 3'(p);
        i_base_addr   = 16'(base);
    endtask

    task automatic run_pass(input int h, input int k, input int c,
                            input int s, input int p, input int base,
                            input int ready_pct, input int abort_at,
                            input bit noise);
        int  n;
        int  idx;
        int  cyc;
        int  limit;
        bit  rdy;
        build_model(h, k, c, s, p, base);
        got_q.delete();
        n     = exp_q.size();
        limit = n * 20 + 100;
        @(negedge clk);
        drive_cfg(h, k, c, s, p, base);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < limit) begin
            if (abort_at >= 0 && idx == abort_at) begin
                rstn = 1'b0;
                #1;
                chk("rst_out", {o_valid, o_busy, o_done, o_err, o_pad,
                                o_col_last, o_last, o_addr}, 32'd0);
                @(negedge clk);
                rstn    = 1'b1;
                i_ready = 1'b0;
                @(negedge clk);
                chk("rst_idle", {29'd0, o_valid, o_busy, o_done}, 32'd0);
                return;
            end
            rdy     = ($urandom_range(99) < ready_pct);
            i_ready = rdy;
            if (noise) begin
                i_start = 1'($urandom_range(1));
                drive_cfg($urandom_range(255), $urandom_range(15),
                          $urandom_range(255), $urandom_range(7),
                          $urandom_range(7), $urandom_range(65535));
            end
            chk("valid", 32'(o_valid), 32'd1);
            chk("busy", 32'(o_busy), 32'd1);
            chk("early_done", 32'(o_done), 32'd0);
            chk("elem", pack_out(), exp_q[idx]);
            if (rdy && o_valid) begin
                got_q.push_back(pack_out());
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        i_start = 1'b0;
        i_ready = 1'b0;
        if (cyc >= limit) chk("timeout", 32'(idx), 32'(n));
        chk("done_pulse", {29'd0, o_done, o_valid, o_busy}, 32'd4);
        @(negedge clk);
        chk("after_done", {29'd0, o_done, o_valid, o_busy}, 32'd0);
    endtask

    task automatic run_illegal(input int h, input int k, input int c,
                               input int s, input int p);
        @(negedge clk);
        drive_cfg(h, k, c, s, p, 0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("err_pulse", 32'(o_err), 32'd1);
        chk("err_valid", 32'(o_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("err_quiet", {28'd0, o_err, o_valid, o_busy, o_done}, 32'd0);
        end
    endtask

    initial begin
        int h;
        int k;
        int c;
        int s;
        int p;
        int kmax;
        checks  = 0;
        errors  = 0;
        rstn    = 1'b0;
        i_start = 1'b0;
        i_ready = 1'b0;
        drive_cfg(0, 0, 0, 0, 0, 0);
        #12;
        chk("reset", {o_valid, o_busy, o_done, o_err, o_pad,
                      o_col_last, o_last, o_addr}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_pass(4, 3, 1, 1, 0, 0, 100, -1, 1'b0);
        chk("t1_count", 32'(got_q.size()), 32'd36);
        chk("t1_c0e3", got_q[3] >> 3, 32'd4);
        chk("t1_c3e0", got_q[27] >> 3, 32'd5);
        chk("t1_cl8", 32'(got_q[8][1]), 32'd1);
        chk("t1_last", 32'(got_q[35][0]), 32'd1);

        run_pass(3, 3, 1, 1, 1, 0, 100, -1, 1'b0);
        chk("t2_count", 32'(got_q.size()), 32'd81);
        chk("t2_padpat", {23'd0, got_q[0][2], got_q[1][2], got_q[2][2],
                          got_q[3][2], got_q[4][2], got_q[5][2],
                          got_q[6][2], got_q[7][2], got_q[8][2]},
            32'b1_1110_0100);

        run_pass(5, 3, 2, 2, 0, 16'h100, 100, -1, 1'b0);
        chk("t3_count", 32'(got_q.size()), 32'd72);
        chk("t3_c0e9", got_q[9] >> 3, 32'h119);
        chk("t3_c1e0", got_q[18] >> 3, 32'h102);

        run_pass(4, 3, 1, 1, 0, 0, 50, -1, 1'b1);
        chk("t4_count", 32'(got_q.size()), 32'd36);

        run_illegal(2, 5, 1, 1, 1);
        run_illegal(4, 3, 1, 0, 0);

        run_pass(4, 3, 1, 1, 0, 0, 100, 10, 1'b0);
        run_pass(4, 3, 1, 1, 0, 0, 70, -1, 1'b1);

        for (int t = 0; t < 6; t++) begin
            h    = $urandom_range(6, 1);
            p    = $urandom_range(2, 0);
            kmax = (h + 2 * p < 4) ? h + 2 * p : 4;
            k    = $urandom_range(kmax, 1);
            c    = $urandom_range(2, 1);
            s    = $urandom_range(3, 1);
            run_pass(h, k, c, s, p, $urandom_range(65535),
                     $urandom_range(100, 40), -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
